// File: rtl/ahb_reg_bank.sv
// Software-visible register bank behind the AHB slave front-end: ID, sticky
// event pending/mask with interrupt, read/write control words and live status words.
module ahb_reg_bank #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned N_CTRL     = 4,
    parameter int unsigned N_STAT     = 4,
    parameter logic [31:0] ID_VALUE   = 32'hC0DE_0001
) (
    input  logic                    ahb_clk,
    input  logic                    ahb_resetn,
    input  logic [ADDR_WIDTH-1:0]   addr_reg,
    input  logic                    rd,
    input  logic                    wr,
    input  logic [31:0]             ahb_hwdata,
    output logic [31:0]             ahb_hrdata,
    input  logic [31:0]             ev_in,
    input  logic [32*N_STAT-1:0]    stat_in,
    output logic [32*N_CTRL-1:0]    ctrl_out,
    output logic [N_CTRL-1:0]       ctrl_wstb,
    output logic                    irq
);

    localparam int unsigned A_ID      = 0;
    localparam int unsigned A_PEND    = 1;
    localparam int unsigned A_MASK    = 2;
    localparam int unsigned CTRL_BASE = 3;
    localparam int unsigned STAT_BASE = 3 + N_CTRL;

    logic [31:0]        r_hrdata;
    logic [31:0]        r_ev_pend;
    logic [31:0]        r_ev_mask;
    logic [31:0]        r_ctrl [N_CTRL];
    logic [N_CTRL-1:0]  r_wstb;
    logic               r_irq;

    logic [31:0]        w_addr;
    logic               w_wr_pend;
    logic               w_wr_mask;
    logic [N_CTRL-1:0]  w_wr_ctrl;
    logic [31:0]        w_pend_next;
    logic [31:0]        w_mask_next;
    logic [31:0]        w_rdata;

    assign w_addr    = 32'(addr_reg);
    assign w_wr_pend = wr && (w_addr == A_PEND);
    assign w_wr_mask = wr && (w_addr == A_MASK);

    always_comb begin
        w_wr_ctrl = '0;
        for (int k = 0; k < int'(N_CTRL); k++) begin
            w_wr_ctrl[k] = wr && (w_addr == CTRL_BASE + 32'(k));
        end
    end

    // New event pulses override a software clear of the same bit.
    assign w_pend_next = (r_ev_pend & ~(w_wr_pend ? ahb_hwdata : 32'h0)) | ev_in;
    assign w_mask_next = w_wr_mask ? ahb_hwdata : r_ev_mask;

    // Read mux uses pre-write state, so a colliding rd/wr returns the old value.
    always_comb begin
        w_rdata = '0;
        if (w_addr == A_ID) begin
            w_rdata = ID_VALUE;
        end else if (w_addr == A_PEND) begin
            w_rdata = r_ev_pend;
        end else if (w_addr == A_MASK) begin
            w_rdata = r_ev_mask;
        end
        for (int k = 0; k < int'(N_CTRL); k++) begin
            if (w_addr == CTRL_BASE + 32'(k)) begin
                w_rdata = r_ctrl[k];
            end
        end
        for (int k = 0; k < int'(N_STAT); k++) begin
            if (w_addr == STAT_BASE + 32'(k)) begin
                w_rdata = stat_in[32*k +: 32];
            end
        end
    end

    always_ff @(posedge ahb_clk) begin
        if (!ahb_resetn) begin
            r_hrdata  <= '0;
            r_ev_pend <= '0;
            r_ev_mask <= '0;
            r_wstb    <= '0;
            r_irq     <= 1'b0;
            for (int k = 0; k < int'(N_CTRL); k++) begin
                r_ctrl[k] <= '0;
            end
        end else begin
            if (rd) begin
                r_hrdata <= w_rdata;
            end
            r_ev_pend <= w_pend_next;
            r_ev_mask <= w_mask_next;
            r_irq     <= |(w_pend_next & w_mask_next);
            r_wstb    <= w_wr_ctrl;
            for (int k = 0; k < int'(N_CTRL); k++) begin
                if (w_wr_ctrl[k]) begin
                    r_ctrl[k] <= ahb_hwdata;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(N_CTRL); g++) begin : g_ctrl_out
        assign ctrl_out[32*g +: 32] = r_ctrl[g];
    end

    assign ahb_hrdata = r_hrdata;
    assign ctrl_wstb  = r_wstb;
    assign irq        = r_irq;

endmodule

// File: tb/tb_ahb_reg_bank.sv
// Directed bench for ahb_reg_bank: a register-map model is stepped every clock
// and compared each cycle, alongside hand-computed literal expectations.
module tb_ahb_reg_bank;

    localparam int NC = 4;
    localparam int NS = 4;

    logic             ahb_clk = 1'b0;
    logic             ahb_resetn;
    logic [3:0]       addr_reg;
    logic             rd;
    logic             wr;
    logic [31:0]      ahb_hwdata;
    logic [31:0]      ahb_hrdata;
    logic [31:0]      ev_in;
    logic [32*NS-1:0] stat_in;
    logic [32*NC-1:0] ctrl_out;
    logic [NC-1:0]    ctrl_wstb;
    logic             irq;

    int n_tests = 0;
    int n_fail  = 0;

    ahb_reg_bank #(
        .ADDR_WIDTH(4), .N_CTRL(NC), .N_STAT(NS), .ID_VALUE(32'hC0DE_0001)
    ) dut (
        .ahb_clk(ahb_clk), .ahb_resetn(ahb_resetn), .addr_reg(addr_reg),
        .rd(rd), .wr(wr), .ahb_hwdata(ahb_hwdata), .ahb_hrdata(ahb_hrdata),
        .ev_in(ev_in), .stat_in(stat_in), .ctrl_out(ctrl_out),
        .ctrl_wstb(ctrl_wstb), .irq(irq)
    );

    always #5 ahb_clk = ~ahb_clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register-map model
    logic        m_valid = 1'b0;
    logic [31:0] m_hr, m_pend, m_mask, m_rdv;
    logic [31:0] m_ctrl [NC];
    logic [NC-1:0] m_wstb;
    logic        m_irq;
    int          m_a;

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'hC0DE_0001;
        if (a == 1) return m_pend;
        if (a == 2) return m_mask;
        if (a >= 3 && a < 3 + NC) return m_ctrl[a-3];
        if (a >= 3 + NC && a < 3 + NC + NS) return stat_in[32*(a-3-NC) +: 32];
        return 32'h0;
    endfunction

    always @(posedge ahb_clk) begin
        if (!ahb_resetn) begin
            m_hr = 0; m_pend = 0; m_mask = 0; m_wstb = 0; m_irq = 0;
            for (int k = 0; k < NC; k++) m_ctrl[k] = 0;
            m_valid = 1'b1;
        end else begin
            m_a    = int'(addr_reg);
            m_rdv  = m_read(m_a);
            m_wstb = 0;
            if (wr) begin
                if (m_a == 1) m_pend = m_pend & ~ahb_hwdata;
                else if (m_a == 2) m_mask = ahb_hwdata;
                else if (m_a >= 3 && m_a < 3 + NC) begin
                    m_ctrl[m_a-3] = ahb_hwdata;
                    m_wstb[m_a-3] = 1'b1;
                end
            end
            m_pend = m_pend | ev_in;
            m_irq  = |(m_pend & m_mask);
            if (rd) m_hr = m_rdv;
        end
    end

    always @(negedge ahb_clk) begin
        if (m_valid) begin
            check("cmp_hrdata", 128'(ahb_hrdata), 128'(m_hr));
            check("cmp_ctrl_out", ctrl_out, {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
            check("cmp_ctrl_wstb", 128'(ctrl_wstb), 128'(m_wstb));
            check("cmp_irq", 128'(irq), 128'(m_irq));
        end
    end

    task automatic cyc(input logic r, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic [31:0] ev);
        @(negedge ahb_clk);
        rd = r; wr = w; addr_reg = a; ahb_hwdata = d; ev_in = ev;
        @(negedge ahb_clk);
        rd = 1'b0; wr = 1'b0; ev_in = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ahb_resetn = 1'b0; rd = 0; wr = 0; addr_reg = 0; ahb_hwdata = 0; ev_in = 0;
        stat_in = {32'h4444_DDDD, 32'h3333_CCCC, 32'h2222_BBBB, 32'h1111_AAAA};
        repeat (2) @(negedge ahb_clk);
        check("rst_hrdata", 128'(ahb_hrdata), 128'h0);
        check("rst_ctrl", ctrl_out, 128'h0);
        check("rst_wstb", 128'(ctrl_wstb), 128'h0);
        check("rst_irq", 128'(irq), 128'h0);
        ahb_resetn = 1'b1;

        cyc(1, 0, 0, 0, 0);
        check("id_read", 128'(ahb_hrdata), 128'hC0DE_0001);

        cyc(0, 1, 4, 32'hA5A5_0F0F, 0);
        check("ctrl1_wr", ctrl_out, {64'h0, 32'hA5A5_0F0F, 32'h0});
        check("ctrl1_wstb", 128'(ctrl_wstb), 128'b0010);
        @(negedge ahb_clk);
        check("ctrl1_wstb_drop", 128'(ctrl_wstb), 128'h0);
        cyc(1, 0, 4, 0, 0);
        check("ctrl1_rd", 128'(ahb_hrdata), 128'hA5A5_0F0F);

        cyc(0, 1, 0, 32'hFFFF_FFFF, 0);
        check("wr_id_wstb", 128'(ctrl_wstb), 128'h0);
        cyc(0, 1, 7, 32'hFFFF_FFFF, 0);
        check("wr_stat_wstb", 128'(ctrl_wstb), 128'h0);
        cyc(0, 1, 15, 32'hFFFF_FFFF, 0);
        check("wr_hole_wstb", 128'(ctrl_wstb), 128'h0);
        check("wr_ignored_ctrl", ctrl_out, {64'h0, 32'hA5A5_0F0F, 32'h0});
        cyc(1, 0, 0, 0, 0);
        check("id_after_wr", 128'(ahb_hrdata), 128'hC0DE_0001);
        cyc(1, 0, 15, 0, 0);
        check("hole_rd", 128'(ahb_hrdata), 128'h0);
        cyc(1, 0, 7, 0, 0);
        check("stat0_rd", 128'(ahb_hrdata), 128'h1111_AAAA);
        stat_in[63:32] = 32'h5555_0000;
        cyc(1, 0, 8, 0, 0);
        check("stat1_live", 128'(ahb_hrdata), 128'h5555_0000);

        cyc(0, 1, 2, 32'h4, 0);
        check("mask_no_irq", 128'(irq), 128'h0);
        cyc(0, 0, 0, 0, 32'h6);
        check("ev_irq", 128'(irq), 128'h1);
        cyc(1, 0, 1, 0, 0);
        check("pend_6", 128'(ahb_hrdata), 128'h6);
        cyc(0, 1, 1, 32'h4, 0);
        check("clr_irq", 128'(irq), 128'h0);
        cyc(1, 0, 1, 0, 0);
        check("pend_2", 128'(ahb_hrdata), 128'h2);

        cyc(0, 1, 2, 32'h1, 0);
        check("mask1_irq", 128'(irq), 128'h0);
        cyc(0, 0, 0, 0, 32'h1);
        check("ev0_irq", 128'(irq), 128'h1);
        cyc(0, 1, 1, 32'h1, 32'h1);
        check("race_irq", 128'(irq), 128'h1);
        cyc(1, 0, 1, 0, 0);
        check("race_pend", 128'(ahb_hrdata), 128'h3);
        cyc(0, 1, 1, 32'h1, 0);
        check("clr0_irq", 128'(irq), 128'h0);
        cyc(1, 0, 1, 0, 0);
        check("pend_after_clr0", 128'(ahb_hrdata), 128'h2);

        cyc(1, 1, 2, 32'hF0, 0);
        check("rdwr_old", 128'(ahb_hrdata), 128'h1);
        cyc(1, 0, 2, 0, 0);
        check("rdwr_new", 128'(ahb_hrdata), 128'hF0);
        cyc(0, 1, 2, 32'h2, 0);
        check("unmask_irq", 128'(irq), 128'h1);
        cyc(0, 1, 2, 32'h0, 0);
        check("mask_off_irq", 128'(irq), 128'h0);

        @(negedge ahb_clk);
        wr = 1; addr_reg = 3; ahb_hwdata = 32'h11;
        @(negedge ahb_clk);
        check("b2b_wstb0", 128'(ctrl_wstb), 128'b0001);
        addr_reg = 5; ahb_hwdata = 32'h55;
        @(negedge ahb_clk);
        wr = 0;
        check("b2b_wstb2", 128'(ctrl_wstb), 128'b0100);
        check("b2b_ctrl", ctrl_out, {32'h0, 32'h55, 32'hA5A5_0F0F, 32'h11});

        @(negedge ahb_clk);
        ahb_resetn = 1'b0; wr = 1; addr_reg = 3; ahb_hwdata = 32'hDEAD_BEEF;
        @(negedge ahb_clk);
        check("midrst_ctrl", ctrl_out, 128'h0);
        check("midrst_wstb", 128'(ctrl_wstb), 128'h0);
        check("midrst_hrdata", 128'(ahb_hrdata), 128'h0);
        ahb_resetn = 1'b1; wr = 0;
        cyc(1, 0, 4, 0, 0);
        check("postrst_ctrl1", 128'(ahb_hrdata), 128'h0);
        cyc(0, 1, 3, 32'h1234, 0);
        check("postrst_wr", ctrl_out, 128'h1234);
        check("postrst_wstb", 128'(ctrl_wstb), 128'b0001);
        @(negedge ahb_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
